// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, NR combinational read ports and one writeback port.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight writeback to matching read ports.
module regfile_sb #(
  parameter int N    = 64,
  parameter int REGS = 32,
  parameter int NR   = 2,
  localparam int AW  = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*N-1:0]  rd,
  output logic [NR-1:0]    rbusy,
  input  logic            we3,
  input  logic [AW-1:0]   wa3,
  input  logic [N-1:0]    wd3,
  input  logic            iss,
  input  logic [AW-1:0]   iwa,
  output logic [AW:0]     pend_cnt
);

  localparam logic [AW-1:0] ZR = AW'(REGS - 1);

  logic [N-1:0]    regs [REGS];
  logic [REGS-1:0] busy;

  logic we_ok;
  logic iss_ok;
  logic cnt_inc;
  logic cnt_dec;

  assign we_ok  = we3 && (wa3 != ZR);
  assign iss_ok = iss && (iwa != ZR);

  // Count moves only on real busy transitions; an issue onto the same address as the
  // writeback wins, so that writeback never decrements.
  assign cnt_inc = iss_ok && !busy[iwa];
  assign cnt_dec = we_ok && busy[wa3] && !(iss_ok && (iwa == wa3));

  // NOTE: the register array is reset to known contents, so it is built from flops
  // rather than a RAM macro; a RAM cannot be initialised asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= (i == REGS - 1) ? '0 : N'(i);
      end
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (we_ok) begin
        regs[wa3] <= wd3;
        busy[wa3] <= 1'b0;
      end
      // NOTE: with non-blocking assignments the last write in the block wins, which
      // is exactly what gives issue priority over writeback clear on the same bit.
      if (iss_ok) begin
        busy[iwa] <= 1'b1;
      end
      pend_cnt <= pend_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    rd    = '0;
    rbusy = '0;
    addr  = '0;
    for (int k = 0; k < NR; k++) begin
      addr = ra[k*AW +: AW];
      if (addr == ZR) begin
        rd[k*N +: N] = '0;
        rbusy[k]     = 1'b0;
      end else begin
        rd[k*N +: N] = regs[addr];
        rbusy[k]     = busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (wa3 == addr)) begin
          rd[k*N +: N] = wd3;
          rbusy[k]     = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random traffic,
// compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

  localparam int N    = 64;
  localparam int REGS = 32;
  localparam int NR   = 2;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*AW-1:0] ra;
  logic [NR*N-1:0]  rd;
  logic [NR-1:0]    rbusy;
  logic            we3;
  logic [AW-1:0]   wa3;
  logic [N-1:0]    wd3;
  logic            iss;
  logic [AW-1:0]   iwa;
  logic [AW:0]     pend_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] mreg  [REGS];
  bit          mbusy [REGS];

  regfile_sb #(.N(N), .REGS(REGS), .NR(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .iss      (iss),
    .iwa      (iwa),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < REGS; i++) begin
      mreg[i]  = (i == REGS - 1) ? 64'd0 : 64'(i);
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic int model_pend();
    int c = 0;
    for (int i = 0; i < REGS; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == a && a != 5'd31) return wd3;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == a && a != 5'd31) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  task automatic check_ports(input string tag);
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      check({tag, "_rd"}, rd[k*N +: N], exp_rd(a));
      check({tag, "_rbusy"}, 64'(rbusy[k]), 64'(exp_busy(a)));
    end
    check({tag, "_pend"}, 64'(pend_cnt), 64'(model_pend()));
  endtask

  // One rising edge; the model applies the writeback first, then the issue, so issue wins.
  task automatic edge_step();
    logic          s_we, s_iss, s_rst;
    logic [AW-1:0] s_wa, s_iwa;
    logic [N-1:0]  s_wd;
    s_we = we3; s_wa = wa3; s_wd = wd3; s_iss = iss; s_iwa = iwa;
    @(posedge clk);
    s_rst = rst_n;
    if (s_rst) begin
      if (s_we && s_wa != 5'd31) begin
        mreg[s_wa]  = s_wd;
        mbusy[s_wa] = 1'b0;
      end
      if (s_iss && s_iwa != 5'd31) mbusy[s_iwa] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; wa3 = '0; wd3 = '0; iss = 1'b0; iwa = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    ra    = '0;
    idle_inputs();
    model_reset();

    // Reset contents while held in reset, then after release.
    repeat (2) @(posedge clk);
    #1;
    ra = {5'd31, 5'd5};
    #1;
    check("rst_hold_rd5", rd[63:0], 64'd5);
    check("rst_hold_pend", 64'(pend_cnt), 64'd0);
    rst_n = 1'b1;
    edge_step();
    check("rel_rd5", rd[63:0], 64'd5);
    check("rel_rd31", rd[127:64], 64'd0);
    check("rel_rbusy", 64'(rbusy), 64'd0);
    check_ports("rel");

    // Issue then writeback on r7.
    iss = 1'b1; iwa = 5'd7;
    edge_step();
    iss = 1'b0;
    ra = {5'd7, 5'd7};
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hABCD;
    #1;
    check("r7_between_pend", 64'(pend_cnt), 64'd1);
    check_ports("r7_between");
    edge_step();
    idle_inputs();
    #1;
    check("r7_after_rd", rd[63:0], 64'hABCD);
    check("r7_after_rbusy", 64'(rbusy), 64'd0);
    check("r7_after_pend", 64'(pend_cnt), 64'd0);

    // Same-cycle issue and writeback on r3: issue wins.
    ra = {5'd3, 5'd3};
    iss = 1'b1; iwa = 5'd3; we3 = 1'b1; wa3 = 5'd3; wd3 = 64'd9;
    edge_step();
    idle_inputs();
    #1;
    check("r3_rd", rd[63:0], 64'd9);
    check("r3_rbusy", 64'(rbusy), 64'd3);
    check("r3_pend", 64'(pend_cnt), 64'd1);

    // Zero register ignores write and issue.
    ra = {5'd31, 5'd31};
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFF; iss = 1'b1; iwa = 5'd31;
    #1;
    check_ports("zr_before");
    edge_step();
    idle_inputs();
    #1;
    check("zr_rd", rd[63:0], 64'd0);
    check("zr_rbusy", 64'(rbusy), 64'd0);
    check("zr_pend", 64'(pend_cnt), 64'd1);

    // Same address on both ports while a writeback to it is pending.
    ra = {5'd4, 5'd4};
    we3 = 1'b1; wa3 = 5'd4; wd3 = 64'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd0", rd[63:0], 64'h55);
`else
    check("byp_rd0", rd[63:0], 64'd4);
`endif
    check("byp_ports_equal", rd[127:64], exp_rd(5'd4));
    edge_step();
    idle_inputs();
    #1;
    check("byp_after_rd1", rd[127:64], 64'h55);

    // Fill the scoreboard: every non-zero register busy.
    for (int i = 0; i < REGS - 1; i++) begin
      iss = 1'b1; iwa = AW'(i);
      edge_step();
    end
    idle_inputs();
    #1;
    check("fill_pend", 64'(pend_cnt), 64'd31);
    check_ports("fill");

    // Clear via reset, then pulse reset in the middle of an issue sequence.
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      iss = 1'b1; iwa = AW'(i);
      edge_step();
    end
    check("mid_pend", 64'(pend_cnt), 64'd13);
    iwa = 5'd13;
    ra = {5'd7, 5'd4};
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_pend", 64'(pend_cnt), 64'd0);
    check("mid_rst_rd4", rd[63:0], 64'd4);
    check("mid_rst_rd7", rd[127:64], 64'd7);
    edge_step();
    check("mid_rst_edge_pend", 64'(pend_cnt), 64'd0);
    rst_n = 1'b1;
    edge_step();
    idle_inputs();
    #1;
    check("mid_rel_pend", 64'(pend_cnt), 64'd1);
    check_ports("mid_rel");

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      we3 = 1'($urandom_range(0, 1));
      wa3 = AW'($urandom_range(0, 31));
      wd3 = {$urandom, $urandom};
      iss = 1'($urandom_range(0, 1));
      iwa = AW'($urandom_range(0, 31));
      ra  = {AW'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, 31))};
      #1;
      check_ports("rand");
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
